// File: rtl/clkdiv_cfg_ctrl.sv
// Divisor-update controller for the clock divider: round-robin arbitration between two
// requesters, glitch-safe apply on a divided-clock falling edge, settle window. Option: CLKDIV_CTRL_LOCK_EN.
module clkdiv_cfg_ctrl #(
    parameter int DIV_W      = 16,
    parameter int RESET_DIV  = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
`ifdef CLKDIV_CTRL_LOCK_EN
    input  logic             i_lock,
`endif
    input  logic             i_req0_valid,
    input  logic [DIV_W-1:0] i_req0_div,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [DIV_W-1:0] i_req1_div,
    output logic             o_req1_ready,
    input  logic             i_slow_clk,
    output logic [DIV_W-1:0] o_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_grant_id,
    output logic             o_timeout
);

    localparam int TW     = DIV_W + 2;
    localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, SETTLE} state_t;

    state_t             state_q, state_d;
    logic               slow_q;
    logic               rr_q;
    logic [DIV_W-1:0]   div_pend_q;
    logic [TW-1:0]      tcnt_q;
    logic [SCNT_W-1:0]  scnt_q;

    logic               fall;
    logic               lock_blk;
    logic               can_grant;
    logic               any_req;
    logic               win_id;
    logic               accept;
    logic [DIV_W-1:0]   new_div;
    logic               bypass;
    logic [TW-1:0]      tcnt_inc;
    logic [TW-1:0]      t_bound;
    logic               tmo_hit;
    logic               settle_end;

`ifdef CLKDIV_CTRL_LOCK_EN
    assign lock_blk = i_lock;
`else
    assign lock_blk = 1'b0;
`endif

    // i_slow_clk is produced from i_clk, so a single flop is enough for edge detection
    assign fall = slow_q & ~i_slow_clk;

    // No grant in the o_done cycle; reset also masks the combinational ready
    assign can_grant = (state_q == IDLE) && !o_done && !i_rst && !lock_blk;
    assign any_req   = i_req0_valid | i_req1_valid;
    assign win_id    = (i_req0_valid && i_req1_valid) ? rr_q : i_req1_valid;
    assign accept    = can_grant && any_req;
    assign new_div   = win_id ? i_req1_div : i_req0_div;

    // Below 2 the divider passes i_clk straight through, so no slow edge will ever come
    assign bypass = (o_divisor < DIV_W'(2)) || (new_div == o_divisor);

    // Bound is formed at DIV_W+2 bits so 2*65535+8 cannot wrap
    assign t_bound    = {1'b0, o_divisor, 1'b0} + TW'(8);
    assign tcnt_inc   = tcnt_q + TW'(1);
    assign tmo_hit    = (state_q == WAIT_EDGE) && !fall && (tcnt_inc == t_bound);
    assign settle_end = (state_q == SETTLE) && (scnt_q == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = bypass ? SETTLE : WAIT_EDGE;
            WAIT_EDGE: if (fall || tmo_hit) state_d = SETTLE;
            SETTLE:    if (scnt_q == '0) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (state_q != IDLE);
        o_req0_ready = accept && !win_id;
        o_req1_ready = accept && win_id;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            slow_q     <= 1'b0;
            rr_q       <= 1'b0;
            o_divisor  <= DIV_W'(RESET_DIV);
            o_done     <= 1'b0;
            o_grant_id <= 1'b0;
            o_timeout  <= 1'b0;
            div_pend_q <= '0;
            tcnt_q     <= '0;
            scnt_q     <= '0;
        end else begin
            slow_q <= i_slow_clk;
            o_done <= settle_end;
            if (accept) begin
                div_pend_q <= new_div;
                o_grant_id <= win_id;
                o_timeout  <= 1'b0;
                rr_q       <= ~win_id;
                tcnt_q     <= '0;
                if (bypass) begin
                    o_divisor <= new_div;
                    scnt_q    <= SETTLE_LOAD;
                end
            end
            if (state_q == WAIT_EDGE) begin
                tcnt_q <= tcnt_inc;
                if (fall || tmo_hit) begin
                    o_divisor <= div_pend_q;
                    scnt_q    <= SETTLE_LOAD;
                end
                if (tmo_hit) o_timeout <= 1'b1;
            end
            if ((state_q == SETTLE) && (scnt_q != '0)) scnt_q <= scnt_q - SCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Directed bench for clkdiv_cfg_ctrl; the lock scenario runs when CLKDIV_CTRL_LOCK_EN is defined.
module tb_clkdiv_cfg_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
`ifdef CLKDIV_CTRL_LOCK_EN
    logic        i_lock = 1'b0;
`endif
    logic        i_req0_valid = 1'b0;
    logic [15:0] i_req0_div = '0;
    logic        o_req0_ready;
    logic        i_req1_valid = 1'b0;
    logic [15:0] i_req1_div = '0;
    logic        o_req1_ready;
    logic        i_slow_clk = 1'b0;
    logic [15:0] o_divisor;
    logic        o_busy;
    logic        o_done;
    logic        o_grant_id;
    logic        o_timeout;

    logic        slow_run = 1'b0;
    logic        slow_lvl = 1'b0;
    int          checks = 0;
    int          errors = 0;

    clkdiv_cfg_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
`ifdef CLKDIV_CTRL_LOCK_EN
        .i_lock       (i_lock),
`endif
        .i_req0_valid (i_req0_valid),
        .i_req0_div   (i_req0_div),
        .o_req0_ready (o_req0_ready),
        .i_req1_valid (i_req1_valid),
        .i_req1_div   (i_req1_div),
        .o_req1_ready (o_req1_ready),
        .i_slow_clk   (i_slow_clk),
        .o_divisor    (o_divisor),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_grant_id   (o_grant_id),
        .o_timeout    (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Divided-clock stand-in: toggles each cycle when running, else holds slow_lvl
    always @(negedge i_clk) i_slow_clk = slow_run ? ~i_slow_clk : slow_lvl;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (o_done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: o_done=%0b after %0d cycles, required 1", o_done, n);
        end
    endtask

    task automatic test_reset_init();
        slow_lvl = 1'b1;
        do_reset();
        checks++; if (o_divisor !== 16'd2) begin errors++; $display("FAIL init_div: got %0d want 2", o_divisor); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL init_busy: got %0b want 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL init_done: got %0b want 0", o_done); end
        checks++; if (o_grant_id !== 1'b0) begin errors++; $display("FAIL init_grant: got %0b want 0", o_grant_id); end
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL init_timeout: got %0b want 0", o_timeout); end
    endtask

    task automatic test_accept();
        slow_run = 1'b0;
        slow_lvl = 1'b1;
        do_reset();
        i_req0_div = 16'd6;
        i_req0_valid = 1'b1;
        #1;
        checks++; if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin errors++; $display("FAIL acc_ready: got %0b%0b want 10", o_req0_ready, o_req1_ready); end
        tick();
        i_req0_valid = 1'b0;
        checks++; if (o_busy !== 1'b1 || o_grant_id !== 1'b0) begin errors++; $display("FAIL acc_busy_grant: got %0b/%0b want 1/0", o_busy, o_grant_id); end
        tick();
        tick();
        checks++; if (o_divisor !== 16'd2) begin errors++; $display("FAIL acc_hold_div: got %0d want 2", o_divisor); end
        slow_lvl = 1'b0;
        tick();
        checks++; if (o_divisor !== 16'd6) begin errors++; $display("FAIL acc_fall_div: got %0d want 6", o_divisor); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL acc_done_early: cycle %0d got %0b want 0", i, o_done); end
        end
        tick();
        checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL acc_done: got done=%0b busy=%0b want 1/0", o_done, o_busy); end
        tick();
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL acc_done_width: got %0b want 0", o_done); end
    endtask

    task automatic test_round_robin();
        slow_run = 1'b1;
        do_reset();
        i_req0_div = 16'd4; i_req0_valid = 1'b1;
        i_req1_div = 16'd8; i_req1_valid = 1'b1;
        #1;
        checks++; if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin errors++; $display("FAIL rr_first: got %0b%0b want 10", o_req0_ready, o_req1_ready); end
        tick();
        i_req0_valid = 1'b0;
        checks++; if (o_grant_id !== 1'b0 || o_req1_ready !== 1'b0) begin errors++; $display("FAIL rr_busy: grant=%0b r1=%0b want 0/0", o_grant_id, o_req1_ready); end
        wait_done(60);
        checks++; if (o_divisor !== 16'd4 || o_req1_ready !== 1'b0) begin errors++; $display("FAIL rr_done0: div=%0d r1=%0b want 4/0", o_divisor, o_req1_ready); end
        tick();
        checks++; if (o_req1_ready !== 1'b1) begin errors++; $display("FAIL rr_req1_ready: got %0b want 1", o_req1_ready); end
        tick();
        checks++; if (o_grant_id !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL rr_grant1: grant=%0b busy=%0b want 1/1", o_grant_id, o_busy); end
        i_req1_div = 16'd9;
        i_req0_div = 16'd5; i_req0_valid = 1'b1;
        wait_done(60);
        checks++; if (o_divisor !== 16'd8 || o_timeout !== 1'b0) begin errors++; $display("FAIL rr_done1: div=%0d to=%0b want 8/0", o_divisor, o_timeout); end
        tick();
        checks++; if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin errors++; $display("FAIL rr_alt0: got %0b%0b want 10", o_req0_ready, o_req1_ready); end
        tick();
        i_req0_valid = 1'b0;
        wait_done(60);
        checks++; if (o_divisor !== 16'd5 || o_grant_id !== 1'b0) begin errors++; $display("FAIL rr_done2: div=%0d grant=%0b want 5/0", o_divisor, o_grant_id); end
        tick();
        checks++; if (o_req1_ready !== 1'b1) begin errors++; $display("FAIL rr_alt1: got %0b want 1", o_req1_ready); end
        tick();
        i_req1_valid = 1'b0;
        wait_done(60);
        checks++; if (o_divisor !== 16'd9) begin errors++; $display("FAIL rr_done3: div=%0d want 9", o_divisor); end
    endtask

    task automatic test_bypass();
        slow_run = 1'b1;
        do_reset();
        i_req0_div = 16'd1; i_req0_valid = 1'b1;
        tick();
        i_req0_valid = 1'b0;
        wait_done(60);
        checks++; if (o_divisor !== 16'd1) begin errors++; $display("FAIL byp_div1: got %0d want 1", o_divisor); end
        slow_run = 1'b0;
        slow_lvl = 1'b0;
        i_req1_div = 16'd10; i_req1_valid = 1'b1;
        #1;
        checks++; if (o_req1_ready !== 1'b0) begin errors++; $display("FAIL byp_done_block: got %0b want 0", o_req1_ready); end
        tick();
        checks++; if (o_req1_ready !== 1'b1) begin errors++; $display("FAIL byp_ready: got %0b want 1", o_req1_ready); end
        tick();
        i_req1_valid = 1'b0;
        checks++; if (o_divisor !== 16'd10 || o_grant_id !== 1'b1) begin errors++; $display("FAIL byp_write: div=%0d grant=%0b want 10/1", o_divisor, o_grant_id); end
        tick(); tick(); tick();
        checks++; if (o_done !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL byp_settle: done=%0b busy=%0b want 0/1", o_done, o_busy); end
        tick();
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL byp_done: got %0b want 1", o_done); end
    endtask

    task automatic test_timeout();
        slow_run = 1'b1;
        do_reset();
        i_req0_div = 16'd8; i_req0_valid = 1'b1;
        tick();
        i_req0_valid = 1'b0;
        wait_done(60);
        checks++; if (o_divisor !== 16'd8) begin errors++; $display("FAIL to_setup: got %0d want 8", o_divisor); end
        slow_run = 1'b0;
        slow_lvl = 1'b0;
        i_req0_div = 16'd3; i_req0_valid = 1'b1;
        tick();
        checks++; if (o_req0_ready !== 1'b1) begin errors++; $display("FAIL to_ready: got %0b want 1", o_req0_ready); end
        tick();
        i_req0_valid = 1'b0;
        for (int i = 1; i <= 23; i++) begin
            tick();
            checks++; if (o_divisor !== 16'd8 || o_timeout !== 1'b0) begin errors++; $display("FAIL to_wait: cycle %0d div=%0d to=%0b want 8/0", i, o_divisor, o_timeout); end
        end
        tick();
        checks++; if (o_divisor !== 16'd3 || o_timeout !== 1'b1) begin errors++; $display("FAIL to_forced: div=%0d to=%0b want 3/1", o_divisor, o_timeout); end
        wait_done(20);
        checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %0b want 1", o_timeout); end
        i_req1_div = 16'd3; i_req1_valid = 1'b1;
        tick();
        checks++; if (o_req1_ready !== 1'b1 || o_timeout !== 1'b1) begin errors++; $display("FAIL to_pre_accept: r1=%0b to=%0b want 1/1", o_req1_ready, o_timeout); end
        tick();
        i_req1_valid = 1'b0;
        checks++; if (o_timeout !== 1'b0 || o_divisor !== 16'd3) begin errors++; $display("FAIL to_clear: to=%0b div=%0d want 0/3", o_timeout, o_divisor); end
    endtask

    task automatic test_reset_mid();
        wait_done(20);
        slow_run = 1'b0;
        slow_lvl = 1'b0;
        i_req1_div = 16'd7; i_req1_valid = 1'b1;
        tick();
        tick();
        checks++; if (o_busy !== 1'b1 || o_grant_id !== 1'b1) begin errors++; $display("FAIL rst_inflight: busy=%0b grant=%0b want 1/1", o_busy, o_grant_id); end
        i_req0_valid = 1'b1;
        i_rst = 1'b1;
        #1;
        checks++; if (o_divisor !== 16'd2) begin errors++; $display("FAIL rst_div: got %0d want 2", o_divisor); end
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_timeout !== 1'b0) begin errors++; $display("FAIL rst_status: busy=%0b done=%0b to=%0b want 000", o_busy, o_done, o_timeout); end
        checks++; if (o_req0_ready !== 1'b0 || o_req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b%0b want 00", o_req0_ready, o_req1_ready); end
        checks++; if (o_grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant: got %0b want 0", o_grant_id); end
        do_reset();
    endtask

`ifdef CLKDIV_CTRL_LOCK_EN
    task automatic test_lock();
        slow_run = 1'b1;
        do_reset();
        i_lock = 1'b1;
        i_req0_div = 16'd6; i_req0_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (o_req0_ready !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL lock_block: cycle %0d ready=%0b busy=%0b want 0/0", i, o_req0_ready, o_busy); end
        end
        i_lock = 1'b0;
        #1;
        checks++; if (o_req0_ready !== 1'b1) begin errors++; $display("FAIL lock_release: got %0b want 1", o_req0_ready); end
        tick();
        i_req0_valid = 1'b0;
        checks++; if (o_busy !== 1'b1 || o_grant_id !== 1'b0) begin errors++; $display("FAIL lock_accept: busy=%0b grant=%0b want 1/0", o_busy, o_grant_id); end
        wait_done(60);
        checks++; if (o_divisor !== 16'd6) begin errors++; $display("FAIL lock_div: got %0d want 6", o_divisor); end
    endtask
`endif

    initial begin
        test_reset_init();
        test_accept();
        test_round_robin();
        test_bypass();
        test_timeout();
        test_reset_mid();
`ifdef CLKDIV_CTRL_LOCK_EN
        test_lock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_cfg_ctrl.md
Name: clkdiv_cfg_ctrl

Overview:
Controller that owns the 16-bit divisor input of the clock divider and shares it between two requesters, such as the register file and a power-management agent. It accepts divisor-change requests over valid/ready handshakes and arbitrates round-robin between them. A new divisor is applied only at a falling edge of the divided clock (glitch-safe boundary), followed by a settle window. It reports busy, done and a timeout status.

Parameters:
DIV_W, 16, width of divisor values
RESET_DIV, 2, o_divisor value after reset
SETTLE_CYC, 4, i_clk cycles spent in SETTLE after each divisor write (must be ≥1)

Ports:
i_clk  in  1  system clock; also the clock that drives the divider
i_rst  in  1  asynchronous, active-high reset
i_req0_valid  in  1  requester 0 has a divisor to apply
i_req0_div  in  DIV_W  requester 0 divisor; held stable while valid
o_req0_ready  out  1  requester 0 accepted this cycle
i_req1_valid  in  1  requester 1 has a divisor to apply
i_req1_div  in  DIV_W  requester 1 divisor
o_req1_ready  out  1  requester 1 accepted this cycle
i_slow_clk  in  1  divided clock fed back from the divider output
o_divisor  out  DIV_W  divisor driven to the divider (registered)
o_busy  out  1  high whenever state != IDLE
o_done  out  1  one-cycle pulse when an update completes
o_grant_id  out  1  id of the last accepted requester (registered)
o_timeout  out  1  sticky; last update was forced by timeout

Behaviour:
- Reset values: o_divisor=RESET_DIV, o_busy=0, o_done=0, o_grant_id=0, o_timeout=0, o_reqN_ready=0, state=IDLE, rr pointer favours requester 0, slow_q=0, counters=0.
- Edge detect: slow_q <= i_slow_clk on every edge; fall = slow_q & ~i_slow_clk. i_slow_clk is generated from i_clk, so it needs no synchronizer.
- States: IDLE, WAIT_EDGE, SETTLE.
- IDLE, grant selection:
  - o_reqN_ready is combinational and asserted only in IDLE, for the single winner.
  - Winner: the only valid requester; if both are valid, the one not granted last (after reset, requester 0).
  - A transfer occurs when valid&ready on an edge. At that edge: latch the divisor, set o_grant_id, clear o_timeout, flip the rr pointer.
- IDLE, bypass vs wait:
  - Bypass applies when current o_divisor < 2 (divider passes i_clk through, so no edges are observable) or the new divisor equals o_divisor.
  - On bypass: write o_divisor at the accept edge, load the settle counter with SETTLE_CYC-1, go to SETTLE.
  - Otherwise go to WAIT_EDGE and clear the timeout counter.
- WAIT_EDGE:
  - Timeout counter (DIV_W+2 bits) increments each cycle.
  - On an edge where fall=1: write o_divisor, go to SETTLE.
  - Else, if the counter equals 2*o_divisor+8: write o_divisor, set o_timeout=1, go to SETTLE.
  - Compute the bound at DIV_W+2 bits, so there is no overflow at a divisor of 65535.
- SETTLE: decrement the counter; at 0, go to IDLE and assert o_done for exactly one cycle (registered, high during the first IDLE cycle). Requests are not accepted in the cycle o_done is high.
- Requests arriving while busy wait; valid must stay asserted. Dropping valid before ready is a protocol violation and is not checked.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight update is lost, and o_divisor reverts to RESET_DIV.
- Divisor values 0 and 1 are legal and are written as given.

Optional Feature:
CLKDIV_CTRL_LOCK_EN
- Defined: adds input port i_lock (1 bit). While i_lock=1, both o_reqN_ready are forced to 0. An update already in flight completes normally, and the rr pointer does not change.
- Undefined: the i_lock port does not exist, and arbitration is never blocked.

Test Plan:
1. Assert i_rst mid-simulation -> immediately o_divisor=2, o_busy=0, o_done=0, o_timeout=0, o_req0_ready=o_req1_ready=0.
2. From reset, req0 valid with div=6, divider running at ÷2 -> accepted the first cycle; o_divisor=6 written on the first edge where fall=1; o_done pulses 4 cycles later; o_grant_id=0.
3. req0 div=4 and req1 div=8 valid together from reset -> req0 accepted first, req1 accepted in the first ready cycle after o_done; with both valid again -> req0 wins (alternation).
4. o_divisor=1 (set via bypass), req1 div=10 -> o_divisor=10 at the accept edge, with no wait on i_slow_clk; o_done high in the cycle 4 cycles after accept.
5. o_divisor=8, i_slow_clk held at 0, req0 div=3 -> forced write after 24 WAIT_EDGE cycles; o_timeout=1 until the next accept.
6. Under CLKDIV_CTRL_LOCK_EN: i_lock=1 with req0 valid -> ready stays 0 for 20 cycles; deassert i_lock -> accepted the same cycle.
